// File: rtl/spi_matrix_cmd_ctrl_if.sv
// SPI byte front end / matrix engine bundle.
// master = command controller, slave = SPI layer + engine.
interface spi_matrix_cmd_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int N      = 4
);
  localparam int ADDR_W = (N * N > 1) ? $clog2(N * N) : 1;

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              frame_active;
  logic [7:0]        tx_data;
  logic              tx_load;
  logic              a_we;
  logic              b_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              busy;
  logic              done;
  logic              res_rd_en;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_rdata;
  logic              irq;

  modport master (
    input  rx_valid, rx_data, frame_active,
    input  busy, done, res_rdata,
    output tx_data, tx_load,
    output a_we, b_we, wr_addr, wr_data,
    output start, res_rd_en, res_addr, irq
  );

  modport slave (
    output rx_valid, rx_data, frame_active,
    output busy, done, res_rdata,
    input  tx_data, tx_load,
    input  a_we, b_we, wr_addr, wr_data,
    input  start, res_rd_en, res_addr, irq
  );
endinterface

// File: rtl/spi_matrix_cmd_ctrl.sv
// SPI byte command controller for the systolic array:
// operand loads, start, result readback and status.
module spi_matrix_cmd_ctrl #(
  parameter int DATA_W = 32,
  parameter int N      = 4,
  parameter bit IRQ_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  spi_matrix_cmd_ctrl_if.master bus
);
  localparam int DEPTH  = N * N;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB     = DATA_W / 8;
  localparam int IDX_W  = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [ADDR_W-1:0] PTR_MAX  = ADDR_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NB - 1);

  localparam logic [7:0] CMD_LD_A = 8'h10;
  localparam logic [7:0] CMD_LD_B = 8'h20;
  localparam logic [7:0] CMD_STRT = 8'h30;
  localparam logic [7:0] CMD_READ = 8'h40;
  localparam logic [7:0] CMD_STAT = 8'h50;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_LOAD,
    S_READ,
    S_STATUS,
    S_IGNORE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] rdw_q, rdw_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              frame_q, frame_d;
  logic              tgt_b_q, tgt_b_d;
  logic              is_rd_q, is_rd_d;
  logic              cap_q, cap_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_load_q, tx_load_d;
  logic              a_we_q, a_we_d;
  logic              b_we_q, b_we_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              start_q, start_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;

  logic [ADDR_W-1:0] ptr_nxt;
  logic [ADDR_W-1:0] addr_b;

  assign ptr_nxt = (ptr_q == PTR_MAX) ? '0 : ptr_q + ADDR_W'(1);
  assign addr_b  = ADDR_W'(bus.rx_data);

  // Next-state and registered-output logic for the command FSM
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    word_d     = word_q;
    rdw_d      = rdw_q;
    err_d      = err_q;
    done_d     = done_q | bus.done;
    frame_d    = bus.frame_active;
    tgt_b_d    = tgt_b_q;
    is_rd_d    = is_rd_q;
    cap_d      = 1'b0;
    tx_data_d  = tx_data_q;
    tx_load_d  = 1'b0;
    a_we_d     = 1'b0;
    b_we_d     = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    start_d    = 1'b0;
    rd_en_d    = 1'b0;
    res_addr_d = res_addr_q;

    if (state_q != S_IDLE && !bus.frame_active) begin
      // frame abort: drop partial word and pending fetch
      state_d = S_IDLE;
      idx_d   = '0;
      word_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.frame_active && !frame_q) state_d = S_CMD;
        end
        S_CMD: begin
          if (bus.rx_valid) begin
            unique case (1'b1)
              (bus.rx_data == CMD_LD_A): begin
                tgt_b_d = 1'b0;
                is_rd_d = 1'b0;
                state_d = S_ADDR;
              end
              (bus.rx_data == CMD_LD_B): begin
                tgt_b_d = 1'b1;
                is_rd_d = 1'b0;
                state_d = S_ADDR;
              end
              (bus.rx_data == CMD_READ): begin
                is_rd_d = 1'b1;
                state_d = S_ADDR;
              end
              (bus.rx_data == CMD_STRT): begin
                if (bus.busy) err_d = 1'b1;
                else start_d = 1'b1;
                state_d = S_IGNORE;
              end
              (bus.rx_data == CMD_STAT): begin
                tx_data_d = {4'b0, err_q, done_q,
                             bus.busy, 1'b1};
                tx_load_d = 1'b1;
                state_d   = S_STATUS;
              end
              default: begin
                err_d   = 1'b1;
                state_d = S_IGNORE;
              end
            endcase
          end
        end
        S_ADDR: begin
          if (bus.rx_valid) begin
            ptr_d = addr_b;
            idx_d = '0;
            if (is_rd_q) begin
              rd_en_d    = 1'b1;
              res_addr_d = addr_b;
              state_d    = S_READ;
            end else begin
              word_d  = '0;
              state_d = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (bus.rx_valid) begin
            if (bus.busy) begin
              err_d = 1'b1;
            end else begin
              word_d[8*int'(idx_q) +: 8] = bus.rx_data;
              if (idx_q == IDX_LAST) begin
                a_we_d    = ~tgt_b_q;
                b_we_d    = tgt_b_q;
                wr_addr_d = ptr_q;
                wr_data_d = word_d;
                ptr_d     = ptr_nxt;
                idx_d     = '0;
              end else begin
                idx_d = idx_q + IDX_W'(1);
              end
            end
          end
        end
        S_READ: begin
          cap_d = rd_en_q;
          if (cap_q) begin
            rdw_d     = bus.res_rdata;
            tx_data_d = bus.res_rdata[7:0];
          end else if (bus.rx_valid && !rd_en_q) begin
            if (idx_q == IDX_LAST) begin
              ptr_d      = ptr_nxt;
              rd_en_d    = 1'b1;
              res_addr_d = ptr_nxt;
              idx_d      = '0;
            end else begin
              idx_d     = idx_q + IDX_W'(1);
              tx_data_d = rdw_q[8*(int'(idx_q)+1) +: 8];
              tx_load_d = 1'b1;
            end
          end
        end
        S_STATUS: begin
          if (bus.rx_valid) begin
            err_d   = 1'b0;
            done_d  = bus.done;
            state_d = S_IGNORE;
          end
        end
        S_IGNORE: begin
          state_d = S_IGNORE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      rdw_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      frame_q    <= 1'b0;
      tgt_b_q    <= 1'b0;
      is_rd_q    <= 1'b0;
      cap_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_load_q  <= 1'b0;
      a_we_q     <= 1'b0;
      b_we_q     <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      start_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      res_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      rdw_q      <= rdw_d;
      err_q      <= err_d;
      done_q     <= done_d;
      frame_q    <= frame_d;
      tgt_b_q    <= tgt_b_d;
      is_rd_q    <= is_rd_d;
      cap_q      <= cap_d;
      tx_data_q  <= tx_data_d;
      tx_load_q  <= tx_load_d;
      a_we_q     <= a_we_d;
      b_we_q     <= b_we_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      start_q    <= start_d;
      rd_en_q    <= rd_en_d;
      res_addr_q <= res_addr_d;
    end
  end

  // Fetched byte 0 goes out in the cycle its data is valid
  assign bus.tx_load   = tx_load_q | cap_q;
  assign bus.tx_data   = cap_q ? bus.res_rdata[7:0] : tx_data_q;
  assign bus.a_we      = a_we_q;
  assign bus.b_we      = b_we_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.start     = start_q;
  assign bus.res_rd_en = rd_en_q;
  assign bus.res_addr  = res_addr_q;
  assign bus.irq       = done_q & IRQ_EN;
endmodule

// File: tb/tb_spi_matrix_cmd_ctrl.sv
// Directed bench for spi_matrix_cmd_ctrl.
// DATA_W=32, N=4, IRQ_EN=1.
module tb_spi_matrix_cmd_ctrl;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_matrix_cmd_ctrl_if #(.DATA_W(32), .N(4)) bus ();

  spi_matrix_cmd_ctrl #(
    .DATA_W(32),
    .N(4),
    .IRQ_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rx_cyc = 0;
  int n_start = 0;

  logic [31:0] res_mem [16];

  logic [7:0]  tx_q [$];
  int          tx_lat [$];
  logic        w_sel [$];
  int          w_addr [$];
  logic [31:0] w_data [$];

  always @(posedge clk) cyc++;

  always @(posedge clk)
    if (bus.res_rd_en) bus.res_rdata <= res_mem[bus.res_addr];

  always @(negedge clk) begin
    if (bus.rx_valid) rx_cyc = cyc;
    if (bus.tx_load) begin
      tx_q.push_back(bus.tx_data);
      tx_lat.push_back(cyc - rx_cyc);
    end
    if (bus.a_we || bus.b_we) begin
      w_sel.push_back(bus.b_we);
      w_addr.push_back(int'(bus.wr_addr));
      w_data.push_back(bus.wr_data);
    end
    if (bus.start) n_start++;
  end

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
    tick(3);
  endtask

  task automatic fbeg();
    bus.frame_active = 1'b1;
    tick(2);
  endtask

  task automatic fend();
    tick(2);
    bus.frame_active = 1'b0;
    tick(3);
  endtask

  task automatic clr();
    tx_q.delete();
    tx_lat.delete();
    w_sel.delete();
    w_addr.delete();
    w_data.delete();
  endtask

  task automatic send_word(logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  function automatic logic [63:0] tx_at(int i);
    if (i < tx_q.size()) return {56'h0, tx_q[i]};
    return 64'hDEAD_0000_0000_0000;
  endfunction

  function automatic logic [63:0] wr_at(int i);
    if (i < w_sel.size())
      return {23'h0, w_sel[i], 8'(w_addr[i]), w_data[i]};
    return 64'hDEAD_0000_0000_0000;
  endfunction

  logic [7:0] exp_rd [8];
  int max_lat;

  initial begin
    rst              = 1'b1;
    bus.rx_valid     = 1'b0;
    bus.rx_data      = 8'h00;
    bus.frame_active = 1'b0;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;
    for (int i = 0; i < 16; i++) res_mem[i] = '0;
    tick(3);

    chk("rst_pulses", {bus.tx_load, bus.a_we, bus.b_we,
        bus.start, bus.res_rd_en, bus.irq}, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_wr", {bus.wr_addr, bus.wr_data}, 0);
    rst = 1'b0;
    tick(2);

    // 1: LOAD_A two words at 0,1
    clr();
    fbeg();
    send(8'h10); send(8'h00);
    send_word(32'h12345678);
    send_word(32'hDEADBEEF);
    fend();
    chk("t1_n", w_sel.size(), 2);
    chk("t1_w0", wr_at(0), {23'h0, 1'b0, 8'd0, 32'h12345678});
    chk("t1_w1", wr_at(1), {23'h0, 1'b0, 8'd1, 32'hDEADBEEF});

    // 2: READ_RES from 0 across a word boundary
    res_mem[0] = 32'h12345678;
    res_mem[1] = 32'hCAFEF00D;
    exp_rd = '{8'h78, 8'h56, 8'h34, 8'h12,
               8'h0D, 8'hF0, 8'hFE, 8'hCA};
    clr();
    fbeg();
    send(8'h40); send(8'h00);
    for (int i = 0; i < 8; i++) send(8'h00);
    fend();
    chk("t2_n", tx_q.size(), 9);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_b%0d", i), tx_at(i), {56'h0, exp_rd[i]});
    max_lat = 0;
    foreach (tx_lat[i]) if (tx_lat[i] > max_lat) max_lat = tx_lat[i];
    chk("t2_lat_le2", max_lat <= 2, 1);
    chk("t2_lat0", tx_lat.size() > 0 ? tx_lat[0] : -1, 2);

    // 3: LOAD_B pointer wrap and address masking
    clr();
    fbeg();
    send(8'h20); send(8'h0F);
    send_word(32'h44332211);
    send_word(32'h88776655);
    fend();
    fbeg();
    send(8'h20); send(8'hFF);
    send_word(32'h04030201);
    fend();
    chk("t3_n", w_sel.size(), 3);
    chk("t3_w15", wr_at(0), {23'h0, 1'b1, 8'd15, 32'h44332211});
    chk("t3_wrap", wr_at(1), {23'h0, 1'b1, 8'd0, 32'h88776655});
    chk("t3_mask", wr_at(2), {23'h0, 1'b1, 8'd15, 32'h04030201});

    // 4: START, done, irq, STATUS
    clr();
    fbeg(); send(8'h30); fend();
    chk("t4_start", n_start, 1);
    bus.done = 1'b1; tick(); bus.done = 1'b0; tick();
    chk("t4_irq1", bus.irq, 1);
    fbeg(); send(8'h50); send(8'h00); fend();
    chk("t4_st05", tx_at(0), 8'h05);
    chk("t4_irq0", bus.irq, 0);
    clr();
    bus.busy = 1'b1;
    fbeg(); send(8'h30); fend();
    chk("t4_nostart", n_start, 1);
    fbeg(); send(8'h50); send(8'h00); fend();
    chk("t4_st0b", tx_at(0), 8'h0B);
    bus.busy = 1'b0;

    // 5: aborted partial word, then clean rewrite
    clr();
    fbeg();
    send(8'h10); send(8'h02);
    send(8'hAA); send(8'hBB);
    fend();
    chk("t5_abort", w_sel.size(), 0);
    fbeg();
    send(8'h10); send(8'h02);
    send_word(32'h04030201);
    fend();
    chk("t5_w", wr_at(0), {23'h0, 1'b0, 8'd2, 32'h04030201});

    // 6: unknown command, then reset mid-read
    clr();
    fbeg();
    send(8'h7E); send(8'h10); send(8'h00);
    send_word(32'h11111111);
    fend();
    chk("t6_ign", w_sel.size(), 0);
    res_mem[3] = 32'hA1B2C3D4;
    fbeg();
    send(8'h40); send(8'h03); send(8'h00);
    chk("t6_rd", tx_at(0) << 8 | tx_at(1), 16'hD4C3);
    clr();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h00;
    rst          = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    tick(3);
    chk("t6_rst_tx", tx_q.size(), 0);
    chk("t6_rst_ptr", int'(dut.ptr_q), 0);
    bus.frame_active = 1'b0;
    rst = 1'b0;
    tick(3);
    chk("t6_idle", int'(dut.state_q), 0);
    chk("t6_tx_none", tx_q.size(), 0);
    fbeg(); send(8'h50); send(8'h00); fend();
    chk("t6_st01", tx_at(0), 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_matrix_cmd_ctrl.md
Name: spi_matrix_cmd_ctrl

Overview:
Parametrised byte-level command controller for the systolic array's SPI front end. Sits between the SPI byte interface (bytes already synchronised into clk) and the matrix engine's A/B operand buffers, start/done handshake and result buffer. Successor to the fixed 32-bit, fixed-address controller:
- configurable word width and array size
- start-address byte with auto-increment and wrap
- frame abort on chip-select release
- sticky error and status reporting

Parameters:
DATA_W, 32, operand/result word width in bits; must be a multiple of 8.
N, 4, array dimension; each buffer holds N*N words. Local ADDR_W = clog2(N*N), minimum 1.
IRQ_EN, 1, 1 drives irq from done_sticky; 0 ties irq low.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle pulse: rx_data holds a received SPI byte
rx_data  in  8  received byte
frame_active  in  1  high while cs_n is asserted (already synchronised)
tx_data  out  8  byte for the SPI layer to shift out next
tx_load  out  1  one-cycle pulse: tx_data valid, latch it
a_we  out  1  write strobe, A buffer
b_we  out  1  write strobe, B buffer
wr_addr  out  ADDR_W  operand write address
wr_data  out  DATA_W  operand write word
start  out  1  one-cycle compute start pulse
busy  in  1  engine computing
done  in  1  one-cycle completion pulse
res_rd_en  out  1  result read strobe
res_addr  out  ADDR_W  result read address
res_rdata  in  DATA_W  result word, valid 1 cycle after res_rd_en
irq  out  1  interrupt = done_sticky & IRQ_EN

Behaviour:
- Reset: all outputs 0. State IDLE. Address pointer 0, byte index 0, done_sticky 0, err 0.
- Commands (first byte of a frame): 0x10 LOAD_A, 0x20 LOAD_B, 0x30 START, 0x40 READ_RES, 0x50 STATUS. Any other code is unknown.
- States: IDLE, CMD, ADDR, LOAD, READ, STATUS, IGNORE.
- IDLE -> CMD on rising frame_active.
- CMD, on rx_valid:
  - LOAD_A/LOAD_B/READ_RES -> ADDR.
  - START: if busy=0, pulse start the next cycle; if busy=1, set err. Then -> IGNORE.
  - STATUS -> STATUS.
  - Unknown -> set err, -> IGNORE.
- ADDR: rx_valid loads pointer = rx_data[ADDR_W-1:0]. Upper bits are ignored. Then -> LOAD or READ.
- LOAD:
  - Bytes arrive LSB first and are assembled into a DATA_W word.
  - On byte DATA_W/8-1: pulse a_we or b_we for one cycle with wr_addr=pointer, then increment pointer. Pointer wraps from N*N-1 to 0.
  - Any LOAD byte received while busy=1 is dropped, err is set, and no write occurs.
- READ:
  - One cycle after the address byte: res_rd_en with res_addr=pointer.
  - The following cycle: capture res_rdata and pulse tx_load with byte 0. Latency is 2 clk from the addr rx_valid to tx_load.
  - Each later rx_valid (dummy byte) -> tx_load of the next byte, the following cycle.
  - After the last byte of a word: increment the pointer (with wrap), fetch the next word, and pulse tx_load with its byte 0, again with 2-clk latency.
- STATUS:
  - Next cycle after entry: tx_load with tx_data = {4'b0, err, done_sticky, busy, 1'b1}.
  - On the next rx_valid: clear err and done_sticky, -> IGNORE.
- IGNORE: rx bytes are discarded until the frame ends.
- done pulse sets done_sticky. If the clear from STATUS and a done pulse occur in the same cycle, set wins.
- Falling frame_active in any state -> IDLE next cycle:
  - A partial word is discarded; no write and no pointer increment.
  - Byte index resets to 0. Any pending read fetch is cancelled.
- A frame that ends in CMD or ADDR performs no action.
- rst asserted mid-operation returns everything to reset values the next cycle, including mid-word and mid-read.
- a_we, b_we, start, tx_load and res_rd_en are never high for more than one cycle per event.

Test Plan:
1. Frame [0x10,0x00, 0x78,0x56,0x34,0x12, 0xEF,0xBE,0xAD,0xDE] -> a_we pulse at addr 0 data 0x12345678, then at addr 1 data 0xDEADBEEF.
2. Result buffer [0]=0x12345678, [1]=0xCAFEF00D; frame [0x40,0x00] + 8 dummy bytes -> tx_data sequence 78,56,34,12,0D,F0,FE,CA, each tx_load ≤2 clk after its triggering rx_valid.
3. N=4: LOAD_B at addr 0x0F with two words -> writes at 15 then 0 (wrap); addr byte 0xFF -> pointer 15.
4. 0x30 with busy=0 -> exactly one start pulse. Engine done -> irq=1. STATUS frame -> 0x05; second byte clears it, irq=0. 0x30 with busy=1 -> no start; STATUS -> 0x0B (err, busy).
5. LOAD_A, addr 2, 2 of 4 bytes, then frame_active low -> no a_we. A new frame writing addr 2 succeeds with freshly assembled data.
6. Unknown cmd 0x7E -> err=1, following bytes ignored. rst during READ mid-word -> tx_load stays 0; state IDLE, pointer 0, err 0.
